// File: rtl/fptd_iteration_controller.sv
// Frame sequencer for the FPTD upper decoder: clear pulse, alternating odd/even
// section enables for a latched iteration target, error-count strobe, result hold.
module fptd_iteration_controller #(
    parameter int MAX_ITER = 32,
    parameter int ITER_W   = 6
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [ITER_W-1:0] Num_Iter,
    input  logic              Abort,
    output logic              Load_Frame,
    output logic              nClear,
    output logic              Enable_Odd,
    output logic              Enable_Even,
    output logic              Enable_Term,
    output logic              Enable_Error_Counter,
    output logic [ITER_W-1:0] Iter_Count,
    output logic              Busy,
    output logic              Out_Valid,
    input  logic              Out_Ready
);

    // state  | meaning
    // IDLE   | waiting for a frame, In_Ready high
    // CLEAR  | one-cycle active-low clear of decoder and error counter
    // ODD    | odd-section half iteration
    // EVEN   | even + termination half iteration, Iter_Count advances
    // COUNT  | one-cycle error-counter enable
    // HOLD   | result valid until Out_Ready (or Abort)
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ODD, S_EVEN, S_COUNT, S_HOLD
    } state_t;

    localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_ITER);
    localparam logic [ITER_W-1:0] ONE_V      = ITER_W'(1);

    state_t            state, state_nxt;
    logic [ITER_W-1:0] iter_count;
    logic [ITER_W-1:0] iter_inc;
    logic [ITER_W-1:0] target;
    logic [ITER_W-1:0] target_nxt;
    logic              accept;

    assign iter_inc = iter_count + ONE_V;

    always_comb begin
        if (Num_Iter == '0)
            target_nxt = ONE_V;
        else if (Num_Iter > MAX_ITER_V)
            target_nxt = MAX_ITER_V;
        else
            target_nxt = Num_Iter;
    end

    always_comb begin
        state_nxt  = state;
        In_Ready   = 1'b0;
        Load_Frame = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid) begin
                    accept     = 1'b1;
                    Load_Frame = 1'b1;
                    state_nxt  = S_CLEAR;
                end
            end
            S_CLEAR: state_nxt = Abort ? S_IDLE : S_ODD;
            S_ODD:   state_nxt = Abort ? S_IDLE : S_EVEN;
            S_EVEN: begin
                if (Abort)
                    state_nxt = S_IDLE;
                else if (iter_inc == target)
                    state_nxt = S_COUNT;
                else
                    state_nxt = S_ODD;
            end
            S_COUNT: state_nxt = Abort ? S_IDLE : S_HOLD;
            S_HOLD: begin
                In_Ready = Out_Ready;
                // Abort outranks a back-to-back accept in the same cycle
                if (Abort) begin
                    state_nxt = S_IDLE;
                end else if (Out_Ready) begin
                    if (In_Valid) begin
                        accept     = 1'b1;
                        Load_Frame = 1'b1;
                        state_nxt  = S_CLEAR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            iter_count <= '0;
            target     <= ONE_V;
        end else begin
            state <= state_nxt;
            if (accept)
                target <= target_nxt;
            if (state == S_CLEAR && !Abort)
                iter_count <= '0;
            else if (state == S_EVEN && !Abort)
                iter_count <= iter_inc;
        end
    end

    assign nClear               = (state != S_CLEAR);
    assign Enable_Odd           = (state == S_ODD);
    assign Enable_Even          = (state == S_EVEN);
    assign Enable_Term          = (state == S_EVEN);
    assign Enable_Error_Counter = (state == S_COUNT);
    assign Out_Valid            = (state == S_HOLD);
    assign Busy                 = (state != S_IDLE);
    assign Iter_Count           = iter_count;

endmodule
